keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad and debounces each press. Each accepted press becomes one (digit, enter) event: `digit` carries the 4-bit key code and `enter` pulses for one clock. This is the producing end of the digit/enter entry interface that the combination-lock logic consumes. It sits between the keypad pins and the lock FSM and has no other clients.

Parameters:
- SCAN_DIV, 1000: clock cycles per scan tick. Each tick samples the columns once. Minimum 4, which covers the 2-flop synchronizer plus settling.
- DEBOUNCE_CNT, 4: consecutive identical tick samples needed to accept a press or a release. Minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- col_in  in  4  keypad columns, active-low, pulled up externally. Asynchronous to clk.
- row_out  out  4  row drive, active-low. Exactly one bit is low at any time.
- digit  out  4  key code of the last accepted press. Held between presses.
- enter  out  1  one-cycle strobe, asserted once per accepted press.
- key_held  out  1  high while an accepted key remains pressed (state HELD).

Behaviour:
- Interface: one clock, `clk`. Reset is synchronous and active-high on port `reset`. All flops clear on the reset clock edge.
- Reset values:
  - row_out = 4'b1110 (row 0).
  - digit = 0, enter = 0, key_held = 0.
  - Synchronizer flops = 4'b1111.
  - Divider, counters and row index = 0.
  - State = SCAN.
- Synchronizer: `col_in` passes through 2 flops before use. All logic uses the synchronized value (`col_s`).
- Divider: counts 0..SCAN_DIV-1 and wraps. `tick` is high on the cycle where count == SCAN_DIV-1. Decisions happen only on tick cycles.
- Key map, row/col, codes 0-15:
  - r0: 1, 2, 3, A=10
  - r1: 4, 5, 6, B=11
  - r2: 7, 8, 9, C=12
  - r3: *=14, 0, #=15, D=13
- Column priority: if several columns are low, the lowest-numbered column wins. Only the currently driven row is ever examined.
- State SCAN:
  - Tick with `col_s` == 4'b1111: the row index advances modulo 4 (0→1→2→3→0) and `row_out` updates on the same edge.
  - Tick with any column low: latch the code, set stable_cnt = 1, go to DEBOUNCE. If DEBOUNCE_CNT == 1, go straight to the accept action instead.
- State DEBOUNCE (row held):
  - Tick with the same code: stable_cnt increments.
  - When stable_cnt reaches DEBOUNCE_CNT, accept the press.
  - Tick with a different code, or with no key: clear stable_cnt, return to SCAN on the same row (no advance), emit nothing.
- Accept action, on the edge after the accepting tick:
  - digit <= code.
  - enter <= 1 for exactly that one cycle.
  - Go to HELD with key_held = 1.
  - Latency: enter rises 1 clock after the tick that took the DEBOUNCE_CNT-th matching sample.
- State HELD (row held, no auto-repeat):
  - Tick with `col_s` == 4'b1111: release_cnt increments.
  - Tick with any column low: release_cnt clears.
  - When release_cnt reaches DEBOUNCE_CNT: key_held = 0, row advances, go to SCAN.
  - A second key pressed in the same row while in HELD produces no event.
- `digit` changes only on accept.
- `enter` is never high on two consecutive cycles. The minimum spacing between strobes is 2*DEBOUNCE_CNT ticks.
- Reset mid-operation: any state returns to SCAN/row 0 on the next edge. No pending enter survives.
- Counter widths are $clog2(SCAN_DIV) and $clog2(DEBOUNCE_CNT+1), with no overflow possible.

Decomposition:
- Package keypad_pkg holds:
  - the state enum {SCAN, DEBOUNCE, HELD};
  - key code constants KEY_A..KEY_D, KEY_STAR, KEY_HASH;
  - function key_code(row, col) returning the 4-bit code.
- Sub-module sync2 (parameterized-width 2-flop synchronizer with sync reset to all-ones) for `col_in`. Everything else lives in keypad_scanner.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=3, and a keypad model that pulls col c low when row r is driven low and key (r,c) is pressed.
- Reset, no keys: row_out = 1110, then 1101, 1011, 0111, 1110, changing every 4 cycles; enter = 0 and digit = 0 throughout.
- Press (r2,c2) and hold 200 cycles: exactly one enter pulse with digit = 9, 1 cycle after the 3rd matching tick; key_held = 1 until 3 release ticks, then row advances to 0111.
- Bounce: key (r1,c0) low for 1 tick, then released → no enter; digit stays 0; scanning resumes.
- Press/release sequence 9, 9, 7, 9 → four single-cycle enter strobes with digit = 9, 9, 7, 9 in order.
- Keys (r0,c0) and (r0,c2) pressed together → one enter, digit = 1.
- Assert reset during DEBOUNCE (after 2 matching ticks) → no enter; row_out = 1110 and key_held = 0 on the next edge.

Source files
------------

// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
//   Shared definitions for the 4x4 matrix keypad scanner:
//     - state_t      : scanner FSM states (SCAN, DEBOUNCE, HELD)
//     - KEY_*        : codes of the non-numeric keys
//     - key_code()   : maps a (row, column) position to its 4-bit key code
//
//   Keypad layout (row / column -> code):
//     r0:  1   2   3   A(10)
//     r1:  4   5   6   B(11)
//     r2:  7   8   9   C(12)
//     r3:  *(14) 0 #(15) D(13)
// ---------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Position-to-code lookup. The numeric block of rows 0..2 and columns 0..2
  // holds 1..9 in reading order; column 3 holds the letter keys and row 3 the
  // star/zero/hash row.
  function automatic logic [3:0] key_code(input logic [1:0] row,
                                          input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      default:  code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// ---------------------------------------------------------------------------
// sync2
//   Two-flop synchronizer for a bus of independent asynchronous inputs.
//   Each bit is synchronized on its own; no cross-bit coherence is implied.
//   Reset loads all-ones so that idle (pulled-up) lines read as inactive.
//
//   Ports:
//     clk    in   1      sampling clock
//     reset  in   1      synchronous reset, active-high
//     d      in   WIDTH  asynchronous input bus
//     q      out  WIDTH  synchronized bus (two clk cycles of latency)
// ---------------------------------------------------------------------------
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk) begin
        if (reset) begin
          meta_reg[gi] <= 1'b1;
          sync_reg[gi] <= 1'b1;
        end else begin
          meta_reg[gi] <= d[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad, debounces presses and releases, and
//   emits one (digit, enter) event per accepted press for the lock FSM.
//
//   One row is driven low at a time. Every SCAN_DIV clocks a scan tick takes
//   one sample of the synchronized columns; all FSM decisions happen on ticks.
//   A press needs DEBOUNCE_CNT identical samples to be accepted, and a release
//   needs DEBOUNCE_CNT all-high samples before scanning resumes. There is no
//   auto-repeat: a held key produces exactly one event.
//
//   Ports:
//     clk       in   1  system clock
//     reset     in   1  synchronous reset, active-high
//     col_in    in   4  keypad columns, active-low, asynchronous to clk
//     row_out   out  4  row drive, active-low, exactly one bit low
//     digit     out  4  code of the last accepted press (held between presses)
//     enter     out  1  one-cycle strobe per accepted press
//     key_held  out  1  high while an accepted key is still pressed
// ---------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] digit,
  output logic       enter,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  // A counter equal to DEB_LAST on a qualifying tick means this tick supplies
  // the DEBOUNCE_CNT-th sample, so the action fires on this same edge.
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CNT - 1);

  // -------------------------------------------------------------------------
  // Column synchronizer
  // -------------------------------------------------------------------------
  logic [3:0] col_s;

  sync2 #(
    .WIDTH (4)
  ) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d     (col_in),
    .q     (col_s)
  );

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [DW-1:0] div_reg,     div_next;
  logic [1:0]    row_reg,     row_next;
  state_t        state_reg,   state_next;
  logic [3:0]    code_reg,    code_next;
  logic [CW-1:0] stable_reg,  stable_next;
  logic [CW-1:0] release_reg, release_next;
  logic [3:0]    digit_reg,   digit_next;
  logic          enter_reg,   enter_next;
  logic          held_reg,    held_next;

  logic          tick;
  logic          any_low;
  logic [1:0]    col_sel;
  logic [3:0]    cur_code;

  // -------------------------------------------------------------------------
  // Scan-tick divider
  // -------------------------------------------------------------------------
  assign tick     = (div_reg == DIV_LAST);
  assign div_next = tick ? '0 : div_reg + DW'(1);

  // -------------------------------------------------------------------------
  // Column decode for the currently driven row. Scanning from the top down
  // lets the lowest low column overwrite the others, giving it priority when
  // several keys in the row are pressed together.
  // -------------------------------------------------------------------------
  assign any_low = (col_s != 4'b1111);

  always_comb begin
    col_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s[i]) begin
        col_sel = 2'(i);
      end
    end
  end

  assign cur_code = key_code(row_reg, col_sel);

  // -------------------------------------------------------------------------
  // Scanner FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    row_next     = row_reg;
    code_next    = code_reg;
    stable_next  = stable_reg;
    release_next = release_reg;
    digit_next   = digit_reg;
    enter_next   = 1'b0;
    held_next    = held_reg;

    if (tick) begin
      case (state_reg)
        SCAN: begin
          if (!any_low) begin
            // Nothing on this row: move on to the next one.
            row_next = row_reg + 2'd1;
          end else begin
            code_next = cur_code;
            if (DEBOUNCE_CNT == 1) begin
              // A single sample is already enough to accept.
              digit_next   = cur_code;
              enter_next   = 1'b1;
              held_next    = 1'b1;
              stable_next  = '0;
              release_next = '0;
              state_next   = HELD;
            end else begin
              stable_next = CW'(1);
              state_next  = DEBOUNCE;
            end
          end
        end

        DEBOUNCE: begin
          if (any_low && (cur_code == code_reg)) begin
            if (stable_reg == DEB_LAST) begin
              digit_next   = code_reg;
              enter_next   = 1'b1;
              held_next    = 1'b1;
              stable_next  = '0;
              release_next = '0;
              state_next   = HELD;
            end else begin
              stable_next = stable_reg + CW'(1);
            end
          end else begin
            // Bounce or a changed key: drop the candidate and rescan the
            // same row without advancing.
            stable_next = '0;
            state_next  = SCAN;
          end
        end

        HELD: begin
          if (!any_low) begin
            if (release_reg == DEB_LAST) begin
              release_next = '0;
              held_next    = 1'b0;
              row_next     = row_reg + 2'd1;
              state_next   = SCAN;
            end else begin
              release_next = release_reg + CW'(1);
            end
          end else begin
            // Any low column (same key or another key on this row) restarts
            // the release count; no new event is produced while held.
            release_next = '0;
          end
        end

        default: begin
          state_next = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg     <= '0;
      row_reg     <= 2'd0;
      state_reg   <= SCAN;
      code_reg    <= 4'd0;
      stable_reg  <= '0;
      release_reg <= '0;
      digit_reg   <= 4'd0;
      enter_reg   <= 1'b0;
      held_reg    <= 1'b0;
    end else begin
      div_reg     <= div_next;
      row_reg     <= row_next;
      state_reg   <= state_next;
      code_reg    <= code_next;
      stable_reg  <= stable_next;
      release_reg <= release_next;
      digit_reg   <= digit_next;
      enter_reg   <= enter_next;
      held_reg    <= held_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. The row drive is a one-cold decode of the registered row index,
  // so it changes on the same edge as the index.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign row_out[gi] = (row_reg != 2'(gi));
    end
  endgenerate

  assign digit    = digit_reg;
  assign enter    = enter_reg;
  assign key_held = held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3.
//   A keypad model pulls column c low while row r is driven and key (r,c) is
//   pressed. Edge numbers below count clock edges after the last reset edge;
//   decisions land on edges that are multiples of 4.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] digit;
  logic       enter;
  logic       key_held;

  logic [15:0] pressed;   // bit r*4+c = key (r,c) is down

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .col_in   (col_in),
    .row_out  (row_out),
    .digit    (digit),
    .enter    (enter),
    .key_held (key_held)
  );

  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
      end
    end
  end

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: every enter strobe is logged with its digit and edge.
  logic [3:0] dq[$];
  int         cq[$];
  logic       prev_en = 1'b0;
  int         dbl = 0;
  always @(negedge clk) begin
    if (enter === 1'b1) begin
      dq.push_back(digit);
      cq.push_back(cyc);
      if (prev_en) dbl <= dbl + 1;
    end
    prev_en <= enter;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    base = cyc;
    dq.delete();
    cq.delete();
  endtask

  task automatic wait_to(input int n);
    while (cyc - base < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [3:0] row_exp [4];
  logic [3:0] seq_key [4];
  logic [3:0] seq_dig [4];

  initial begin
    row_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seq_key = '{4'd10, 4'd10, 4'd8, 4'd10};
    seq_dig = '{4'd9, 4'd9, 4'd7, 4'd9};
    pressed = '0;

    // ---- 1: reset, idle scanning -------------------------------------
    do_reset();
    check("rst_row", 32'(row_out), 32'(4'b1110));
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_enter", 32'(enter), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      wait_to(4*k - 1);
      check("idle_row_before", 32'(row_out), 32'(row_exp[(k-1)%4]));
      wait_to(4*k);
      check("idle_row_after", 32'(row_out), 32'(row_exp[k%4]));
    end
    check("idle_no_enter", 32'(dq.size()), 32'd0);
    check("idle_digit", 32'(digit), 32'd0);

    // ---- 2: press 9 (r2,c2), hold 200 cycles --------------------------
    do_reset();
    pressed[10] = 1'b1;
    wait_to(19);
    check("p9_pre_enter", 32'(enter), 32'd0);
    check("p9_pre_row", 32'(row_out), 32'(4'b1011));
    wait_to(20);
    check("p9_enter", 32'(enter), 32'd1);
    check("p9_digit", 32'(digit), 32'd9);
    check("p9_held", 32'(key_held), 32'd1);
    wait_to(21);
    check("p9_enter_drop", 32'(enter), 32'd0);
    wait_to(200);
    pressed[10] = 1'b0;
    wait_to(211);
    check("p9_held_before_rel", 32'(key_held), 32'd1);
    check("p9_row_before_rel", 32'(row_out), 32'(4'b1011));
    wait_to(212);
    check("p9_held_after_rel", 32'(key_held), 32'd0);
    check("p9_row_after_rel", 32'(row_out), 32'(4'b0111));
    check("p9_count", 32'(dq.size()), 32'd1);
    if (cq.size() > 0) check("p9_enter_edge", 32'(cq[0] - base), 32'd20);

    // ---- 3: bounce on (r1,c0) -----------------------------------------
    do_reset();
    pressed[4] = 1'b1;
    wait_to(8);
    pressed[4] = 1'b0;
    wait_to(12);
    check("bounce_row_hold", 32'(row_out), 32'(4'b1101));
    wait_to(16);
    check("bounce_row_resume", 32'(row_out), 32'(4'b1011));
    wait_to(24);
    check("bounce_no_enter", 32'(dq.size()), 32'd0);
    check("bounce_digit", 32'(digit), 32'd0);
    check("bounce_held", 32'(key_held), 32'd0);

    // ---- 4: sequence 9, 9, 7, 9 ---------------------------------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pressed[seq_key[i]] = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      check("seq_held", 32'(key_held), 32'd1);
      pressed[seq_key[i]] = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      check("seq_released", 32'(key_held), 32'd0);
    end
    check("seq_count", 32'(dq.size()), 32'd4);
    if (dq.size() == 4) begin
      for (int i = 0; i < 4; i++) check("seq_digit", 32'(dq[i]), 32'(seq_dig[i]));
    end

    // ---- 5: (r0,c0) and (r0,c2) together -> digit 1 --------------------
    do_reset();
    pressed[0] = 1'b1;
    pressed[2] = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("multi_held", 32'(key_held), 32'd1);
    check("multi_digit_out", 32'(digit), 32'd1);
    pressed = '0;
    repeat (60) @(posedge clk);
    #1;
    check("multi_count", 32'(dq.size()), 32'd1);
    if (dq.size() > 0) check("multi_digit", 32'(dq[0]), 32'd1);

    // ---- 6: reset during DEBOUNCE --------------------------------------
    do_reset();
    pressed[10] = 1'b1;
    wait_to(17);
    check("mid_row_held", 32'(row_out), 32'(4'b1011));
    check("mid_no_held", 32'(key_held), 32'd0);
    reset = 1'b1;
    pressed = '0;
    wait_to(18);
    check("mid_rst_row", 32'(row_out), 32'(4'b1110));
    check("mid_rst_held", 32'(key_held), 32'd0);
    check("mid_rst_enter", 32'(enter), 32'd0);
    reset = 1'b0;
    wait_to(60);
    check("mid_no_event", 32'(dq.size()), 32'd0);
    check("mid_digit", 32'(digit), 32'd0);

    check("no_double_enter", 32'(dbl), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
